// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared encodings for the multicycle RV32I control path.
// Holds the FSM state type, opcode constants, ALU op classes and the
// select encodings driven onto the datapath muxes and immediate extender.
package rv32i_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_REGA  = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_REGB = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's ALU op class plus instruction fields to ALUControl.
// Ports: ALUOp (op class), Funct3, Funct7b5, Op5 (1 = R-type, 0 = I-type) in;
//        ALUControl out.
module alu_decoder
  import rv32i_pkg::*;
(
  input  alu_op_t    ALUOp,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Op5,
  output logic [2:0] ALUControl
);
  always_comb begin
    ALUControl = ALU_ADD;
    if (ALUOp == ALUOP_SUB) ALUControl = ALU_SUB;
    else if (ALUOp == ALUOP_FUNCT)
      case (Funct3)
        // only R-type may subtract; addi with imm[10]=1 stays an add
        3'b000:  ALUControl = (Op5 & Funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  ALUControl = ALU_SLT;
        3'b110:  ALUControl = ALU_OR;
        3'b111:  ALUControl = ALU_AND;
        default: ALUControl = ALU_ADD;
      endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RV32I datapath.
// Ports: clk, rst_n (async active-low); Op, Funct3, Funct7b5 instruction fields;
//        Zero (ALU flag), MemReady (memory handshake) in.
//        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//        ALUSrcB, ImmSrc, ALUControl datapath controls and Illegal out.
module multicycle_controller
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);
  state_t  state, next;
  alu_op_t alu_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_FETCH;
    else state <= next;
  always_comb begin
    next      = state;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = A_PC;
    ALUSrcB   = B_REGB;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = B_FOUR;
        ResultSrc = RES_ALURESULT;
        // reset forces FETCH, so gate the fetch strobes to keep them low in reset
        IRWrite   = MemReady & rst_n;
        PCWrite   = MemReady & rst_n;
        next      = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_IMM;
        ImmSrc  = IMM_B;
        case (Op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:              next = S_EXECR;
          OP_I:              next = S_EXECI;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_LUI:            next = S_LUI;
          default:           next = S_ILLEGAL;
        endcase
      end
      // Op[5] separates store (1) from load (0)
      S_MEMADR: begin
        ALUSrcA = A_REGA;
        ALUSrcB = B_IMM;
        ImmSrc  = Op[5] ? IMM_S : IMM_I;
        next    = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        next     = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = A_REGA;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = A_REGA;
        ALUSrcB = B_IMM;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      // beq takes the branch on Zero, bne on !Zero
      S_BRANCH: begin
        ALUSrcA = A_REGA;
        alu_op  = ALUOP_SUB;
        PCWrite = Zero ^ Funct3[0];
        next    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_FOUR;
        PCWrite = 1'b1;
        next    = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = A_ZERO;
        ALUSrcB = B_IMM;
        ImmSrc  = IMM_U;
        next    = S_ALUWB;
      end
      S_ILLEGAL: Illegal = 1'b1;
      default:   next = S_FETCH;
    endcase
  end
  alu_decoder u_alu_decoder (
    .ALUOp     (alu_op),
    .Funct3    (Funct3),
    .Funct7b5  (Funct7b5),
    .Op5       (Op[5]),
    .ALUControl(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams against a per-instruction cycle-recipe model.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Op = 7'd0;
  logic [2:0] Funct3 = 3'd0;
  logic       Funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [17:0] got;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic        mr;
    logic [17:0] v;
  } step_t;
  step_t q[$];
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
  );
  always #5 clk = ~clk;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
  task automatic check(input string tag, input logic [17:0] g, input logic [17:0] e);
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, g, e, $time);
  endtask
  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic rw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic [2:0] imm, input logic [2:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction
  function automatic logic [2:0] alu_ri(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  task automatic push(input logic mr, input logic [17:0] v);
    step_t s;
    s.mr = mr;
    s.v = v;
    q.push_back(s);
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic fetch(input int w);
    repeat (w) push(1'b0, mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
    push(1'b1, mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
  endtask
  task automatic decode();
    push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0));
  endtask
  task automatic aluwb();
    push(rb(), mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
  endtask
  task automatic run(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      MemReady = s.mr;
      #1;
      check(tag, got, s.v);
    end
  endtask
  // k: 0 load, 1 store, 2 R, 3 I, 4 branch, 5 jal, 6 lui
  task automatic instr(input string tag, input int k, input int wf, input int wm,
      input logic [2:0] f3, input logic f7, input logic z);
    case (k)
      0: Op = 7'b0000011;
      1: Op = 7'b0100011;
      2: Op = 7'b0110011;
      3: Op = 7'b0010011;
      4: Op = 7'b1100011;
      5: Op = 7'b1101111;
      default: Op = 7'b0110111;
    endcase
    Funct3 = f3;
    Funct7b5 = f7;
    Zero = z;
    fetch(wf);
    decode();
    case (k)
      0: begin
        push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
        repeat (wm) push(1'b0, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
        push(1'b1, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
        push(rb(), mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0));
      end
      1: begin
        push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 0));
        repeat (wm) push(1'b0, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
        push(1'b1, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
      end
      2: begin
        push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, alu_ri(f3, f7, 1'b1), 0));
        aluwb();
      end
      3: begin
        push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, alu_ri(f3, f7, 1'b0), 0));
        aluwb();
      end
      4: push(rb(), mk(z ^ f3[0], 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0));
      5: begin
        push(rb(), mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0));
        aluwb();
      end
      default: begin
        push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd3, 3'd0, 0));
        aluwb();
      end
    endcase
    run(tag);
  endtask
  initial begin
    MemReady = 1'b1;
    #1;
    check("reset", got, mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
    MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr("add", 2, 0, 0, 3'b000, 1'b0, 1'b0);
    instr("sub", 2, 1, 0, 3'b000, 1'b1, 1'b0);
    instr("lw", 0, 0, 2, 3'b010, 1'b0, 1'b0);
    instr("beq", 4, 0, 0, 3'b000, 1'b0, 1'b1);
    instr("bne", 4, 0, 0, 3'b001, 1'b0, 1'b1);
    instr("sw", 1, 0, 3, 3'b010, 1'b0, 1'b0);
    instr("addi", 3, 0, 0, 3'b000, 1'b1, 1'b0);
    instr("jal", 5, 2, 0, 3'b000, 1'b0, 1'b0);
    instr("lui", 6, 0, 0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++)
      instr("rand", int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 3'($urandom), rb(), rb());
    Op = 7'b0000000;
    fetch(0);
    decode();
    repeat (10) push(rb(), mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1));
    run("illegal");
    @(negedge clk);
    rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    check("ill_reset", got, mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
    MemReady = 1'b0;
    rst_n = 1'b1;
    instr("post_ill", 2, 0, 0, 3'b111, 1'b0, 1'b0);
    Op = 7'b0000011;
    fetch(0);
    decode();
    push(1'b0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
    push(1'b0, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    run("ld_abort");
    #2;
    rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    check("async_rst", got, mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
    MemReady = 1'b0;
    rst_n = 1'b1;
    instr("post_rst", 3, 0, 0, 3'b110, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      instr("rand2", int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), 3'($urandom), rb(), rb());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: Op  in  7  instruction[6:0]; Funct3  in  3  instruction[14:12]; Funct7b5  in  1  instruction[30].
REQ-004 SHALL have ports: Zero  in  1  ALU zero flag; MemReady  in  1  memory access complete this cycle.
REQ-005 SHALL have outputs: PCWrite 1, AdrSrc 1 (0 PC, 1 Result), MemWrite 1, IRWrite 1, RegWrite 1.
REQ-006 SHALL have outputs: ResultSrc 2 (00 ALUOut, 01 Data, 10 ALUResult); ALUSrcA 2 (00 PC, 01 OldPC, 10 RegA, 11 zero); ALUSrcB 2 (00 RegB, 01 ImmExt, 10 const 4).
REQ-007 SHALL have outputs: ImmSrc 3 (000 I, 001 S, 010 B, 011 U, 100 J, driving the immediate extender); ALUControl 3 (000 add, 001 sub, 010 and, 011 or, 101 slt); Illegal 1.
REQ-008 Clock and reset SHALL be exactly one clock clk and asynchronous active-low reset rst_n.

Function
REQ-009 SHALL be a Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, ILLEGAL; outputs not listed for a state SHALL be 0.
REQ-010 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10; IRWrite=PCWrite=1 only in the cycle MemReady=1; stay in FETCH while MemReady=0; on MemReady=1 go to DECODE.
REQ-011 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add; next by Op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, any other ILLEGAL.
REQ-012 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=000 for load and 001 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-013 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-014 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle held; hold until MemReady=1, then FETCH.
REQ-015 EXECR: ALUSrcA=10, ALUSrcB=00, R-type decode. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, I-type decode. Both next ALUWB. ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-016 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=Zero XOR Funct3[0] (beq 000, bne 001); next FETCH.
REQ-017 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB. LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=011, add; next ALUWB.
REQ-018 ALU decode: add-type states give 000; BRANCH gives 001; R/I decode by Funct3: 000 add (sub if R-type and Funct7b5=1), 010 slt, 110 or, 111 and; other Funct3 SHALL give 000.
REQ-019 ILLEGAL: Illegal=1, all write enables 0, absorbing until reset.
REQ-020 Cycle counts excluding memory wait: load 5, store 4, R/I 4, branch 3, jal 4, lui 4; each MemReady=0 cycle adds exactly one.

Reset
REQ-021 rst_n=0 SHALL force state FETCH immediately, asynchronously and mid-instruction included; all write enables and Illegal SHALL read 0 during reset.
REQ-022 The first rising edge after rst_n deasserts SHALL evaluate FETCH normally.

Structure
REQ-023 State encoding, opcode constants, ImmSrc/ALUControl/mux-select encodings SHALL live in shared package rv32i_pkg.
REQ-024 ALU decode SHALL be sub-module alu_decoder (inputs ALUOp, Funct3, Funct7b5, Op[5]; output ALUControl).

Verification
REQ-025 add x3,x1,x2 (0x002081B3), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in cycle 4.
REQ-026 lw (Op 0000011), MemReady=0 for 2 cycles in MEMREAD -> 7 cycles total; ImmSrc=000 in MEMADR; RegWrite=1 only in MEMWB.
REQ-027 beq with Zero=1 -> PCWrite=1 in BRANCH; bne (Funct3 001) with Zero=1 -> PCWrite=0; ALUControl=001.
REQ-028 sw, MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles; ImmSrc=001 in MEMADR.
REQ-029 Op=0000000 -> ILLEGAL after DECODE, Illegal=1 held 10 cycles; rst_n pulse -> FETCH, Illegal=0.
REQ-030 rst_n asserted during MEMREAD -> state FETCH without waiting for clk; RegWrite never asserted for that load.
